// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter
//   Iterative AES inverse cipher: decrypts one 128-bit block, one round per
//   clock. Round keys are fetched from an external key store through an
//   index/data port that is answered combinationally in the same cycle.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   in_valid   ciphertext valid
//   in_ready   block can accept ciphertext (IDLE only)
//   in_data    ciphertext, FIPS-197 byte order
//   rk_idx     round-key index requested this cycle
//   rk_in      round key for rk_idx (same cycle)
//   out_valid  plaintext valid
//   out_ready  consumer accepts plaintext
//   out_data   plaintext, held until the next result or reset
//   busy       high in every state except IDLE
//
// Byte layout: s[r][c] lives at bits [127-32c-8r -: 8].

module aes_inv_cipher_iter #(
    parameter int Nb = 4,
    parameter int Nr = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] blk_q, blk_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] out_q, out_d;
    logic         ov_q, ov_d;
    logic [127:0] sub_add;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < Nb; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + 4 - r) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    // Multiples by 09/0b/0d/0e built from a shared x2/x4/x8 chain per byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = w[31 - 8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < Nb; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // One shared set of 16 S-boxes serves both ROUND and FINAL; the two
    // only differ in whether InvMixColumns follows the key addition.
    assign sub_add = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            round_q <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            round_q <= round_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        round_d  = round_q;
        out_d    = out_q;
        ov_d     = ov_q;
        rk_idx   = '0;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                rk_idx   = 4'(Nr);
                if (in_valid) begin
                    blk_d   = in_data ^ rk_in;
                    round_d = 4'(Nr - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                rk_idx  = round_q;
                blk_d   = inv_mix_columns(sub_add);
                round_d = round_q - 4'd1;
                if (round_q == 4'd1) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                rk_idx  = '0;
                out_d   = sub_add;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                rk_idx = '0;
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = ov_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: two instances (Nr=10 and Nr=14) fed from
// bench-side key stores; a byte-matrix reference decryptor plus an
// edges-since-acceptance timing model predict every output each cycle.

module tb_aes_inv_cipher_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_s     [2];
    logic         in_valid_s  [2];
    logic         in_ready_s  [2];
    logic [127:0] in_data_s   [2];
    logic [3:0]   rk_idx_s    [2];
    logic [127:0] rk_in_s     [2];
    logic         out_valid_s [2];
    logic         out_ready_s [2];
    logic [127:0] out_data_s  [2];
    logic         busy_s      [2];

    logic [127:0] keys [2][16];
    logic [7:0]   inv_tab [256];
    logic [7:0]   fwd_tab [256];

    int nchk = 0;
    int nerr = 0;

    assign rk_in_s[0] = keys[0][rk_idx_s[0]];
    assign rk_in_s[1] = keys[1][rk_idx_s[1]];

    aes_inv_cipher_iter #(.Nb(4), .Nr(10)) dut_a (
        .clk(clk), .reset(reset_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in_data(in_data_s[0]), .rk_idx(rk_idx_s[0]), .rk_in(rk_in_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0]),
        .busy(busy_s[0])
    );

    aes_inv_cipher_iter #(.Nb(4), .Nr(14)) dut_b (
        .clk(clk), .reset(reset_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in_data(in_data_s[1]), .rk_idx(rk_idx_s[1]), .rk_in(rk_in_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1]),
        .busy(busy_s[1])
    );

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [2047:0] tbl;
        tbl = {
            128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
            128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
            128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
            128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
            128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
            128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
            128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
            128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
        for (int i = 0; i < 256; i++) begin
            inv_tab[i] = tbl[2047 - 8*i -: 8];
        end
        for (int i = 0; i < 256; i++) begin
            fwd_tab[inv_tab[i]] = 8'(i);
        end
    endtask

    task automatic expand_key(input int d, input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {fwd_tab[t[31:24]], fwd_tab[t[23:16]], fwd_tab[t[15:8]], fwd_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = {fwd_tab[t[31:24]], fwd_tab[t[23:16]], fwd_tab[t[15:8]], fwd_tab[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) keys[d][r] = '0;
        for (int r = 0; r <= nr; r++) keys[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook inverse cipher on a 4x4 byte matrix.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input int nr, input int d);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   coef [4];
        logic [127:0] k, o;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        k = keys[d][nr];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = ct[127-32*c-8*r -: 8] ^ k[127-32*c-8*r -: 8];
        for (int rnd = nr - 1; rnd >= 0; rnd--) begin
            k = keys[d][rnd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = inv_tab[s[r][(c - r + 4) % 4]] ^ k[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd > 0) begin
                        s[r][c] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[r][c] = s[r][c] ^ gmul(coef[(j - r + 4) % 4], t[j][c]);
                    end else begin
                        s[r][c] = t[r][c];
                    end
                end
        end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-32*c-8*r -: 8] = s[r][c];
        return o;
    endfunction

    // Timing model: n = edges since acceptance (accepting edge counts as 1),
    // 0 when idle; result is presented at n = Nr+1 until taken.
    int           n     [2] = '{0, 0};
    bit           armed [2] = '{0, 0};
    logic [127:0] exp_data [2];
    logic [127:0] pend     [2];

    always @(posedge clk) begin
        int nr;
        for (int d = 0; d < 2; d++) begin
            nr = (d == 0) ? 10 : 14;
            if (reset_s[d]) begin
                n[d] = 0;
                exp_data[d] = '0;
                armed[d] = 1'b1;
            end else if (n[d] == 0) begin
                if (in_valid_s[d]) begin
                    n[d] = 1;
                    pend[d] = model_decrypt(in_data_s[d], nr, d);
                end
            end else if (n[d] <= nr) begin
                n[d] = n[d] + 1;
                if (n[d] == nr + 1) exp_data[d] = pend[d];
            end else if (out_ready_s[d]) begin
                n[d] = 0;
            end
        end
    end

    always @(negedge clk) begin
        int nr;
        int erk;
        for (int d = 0; d < 2; d++) begin
            if (armed[d]) begin
                nr  = (d == 0) ? 10 : 14;
                erk = (n[d] == 0) ? nr : ((n[d] <= nr) ? nr - n[d] : 0);
                chk($sformatf("cyc%0d_in_ready", d), 128'(in_ready_s[d]), 128'(n[d] == 0));
                chk($sformatf("cyc%0d_busy", d), 128'(busy_s[d]), 128'(n[d] != 0));
                chk($sformatf("cyc%0d_out_valid", d), 128'(out_valid_s[d]), 128'(n[d] == nr + 1));
                chk($sformatf("cyc%0d_out_data", d), out_data_s[d], exp_data[d]);
                chk($sformatf("cyc%0d_rk_idx", d), 128'(rk_idx_s[d]), 128'(erk));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Presents ct for one accepting edge and counts edges until out_valid.
    task automatic send(input int d, input logic [127:0] ct, output int lat);
        in_data_s[d]  = ct;
        in_valid_s[d] = 1'b1;
        step();
        lat = 1;
        in_valid_s[d] = 1'b0;
        while (!out_valid_s[d] && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_valid(input int d, input string name);
        int cnt;
        cnt = 0;
        while (!out_valid_s[d] && cnt < 40) begin
            step();
            cnt++;
        end
        chk(name, 128'(out_valid_s[d]), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int xfers;
        logic [127:0] ct;
        for (int d = 0; d < 2; d++) begin
            reset_s[d] = 1'b1;
            in_valid_s[d] = 1'b0;
            out_ready_s[d] = 1'b0;
            in_data_s[d] = '0;
        end
        build_tables();
        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        expand_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);

        chk("pin_rk10_aes128", keys[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("pin_model_c1", model_decrypt(C1_CT, 10, 0), PT);
        chk("pin_model_c3", model_decrypt(C3_CT, 14, 1), PT);

        step();
        step();
        reset_s[0] = 1'b0;
        reset_s[1] = 1'b0;
        chk("reset_in_ready", 128'(in_ready_s[0]), 128'd1);
        chk("reset_out_valid", 128'(out_valid_s[0]), 128'd0);
        chk("reset_out_data", out_data_s[0], 128'd0);
        chk("reset_busy", 128'(busy_s[0]), 128'd0);
        chk("reset_rk_idx", 128'(rk_idx_s[0]), 128'd10);

        // FIPS-197 C.1
        out_ready_s[0] = 1'b1;
        send(0, C1_CT, lat);
        chk("c1_latency", 128'(lat), 128'd11);
        chk("c1_out_data", out_data_s[0], PT);
        step();
        chk("c1_taken", 128'(out_valid_s[0]), 128'd0);

        // Back-pressure with an ignored in_valid pulse mid-round
        out_ready_s[0] = 1'b0;
        in_data_s[0] = C1_CT;
        in_valid_s[0] = 1'b1;
        step();
        in_valid_s[0] = 1'b0;
        step();
        step();
        in_data_s[0] = 128'hdeadbeef0123456789abcdeffedcba98;
        in_valid_s[0] = 1'b1;
        step();
        in_valid_s[0] = 1'b0;
        chk("busy_in_ready", 128'(in_ready_s[0]), 128'd0);
        wait_valid(0, "bp_valid_rise");
        repeat (20) step();
        chk("bp_valid_held", 128'(out_valid_s[0]), 128'd1);
        chk("bp_data_held", out_data_s[0], PT);
        chk("bp_in_ready", 128'(in_ready_s[0]), 128'd0);
        out_ready_s[0] = 1'b1;
        step();
        chk("bp_taken_valid", 128'(out_valid_s[0]), 128'd0);
        chk("bp_taken_ready", 128'(in_ready_s[0]), 128'd1);
        chk("bp_data_kept", out_data_s[0], PT);

        // Further ciphertext patterns against the reference decryptor
        for (int i = 0; i < 3; i++) begin
            ct = {$urandom, $urandom, $urandom, $urandom};
            send(0, ct, lat);
            chk($sformatf("rand%0d_data", i), out_data_s[0], model_decrypt(ct, 10, 0));
            step();
        end

        // Reset while round counter is at 5
        in_data_s[0] = C1_CT;
        in_valid_s[0] = 1'b1;
        step();
        in_valid_s[0] = 1'b0;
        repeat (4) step();
        chk("mid_rk_idx", 128'(rk_idx_s[0]), 128'd5);
        reset_s[0] = 1'b1;
        step();
        reset_s[0] = 1'b0;
        chk("abort_in_ready", 128'(in_ready_s[0]), 128'd1);
        chk("abort_out_valid", 128'(out_valid_s[0]), 128'd0);
        chk("abort_out_data", out_data_s[0], 128'd0);
        chk("abort_busy", 128'(busy_s[0]), 128'd0);
        send(0, C1_CT, lat);
        chk("after_abort_latency", 128'(lat), 128'd11);
        chk("after_abort_data", out_data_s[0], PT);
        step();

        // Back-to-back with in_valid and out_ready held high
        in_data_s[0] = C1_CT;
        in_valid_s[0] = 1'b1;
        xfers = 0;
        wait_valid(0, "b2b_first_valid");
        chk("b2b_first_data", out_data_s[0], PT);
        step();
        chk("b2b_idle_gap", 128'(in_ready_s[0]), 128'd1);
        step();
        chk("b2b_second_accept", 128'(busy_s[0]), 128'd1);
        in_valid_s[0] = 1'b0;
        wait_valid(0, "b2b_second_valid");
        chk("b2b_second_data", out_data_s[0], PT);
        step();
        chk("b2b_second_taken", 128'(out_valid_s[0]), 128'd0);

        // FIPS-197 C.3 on the Nr=14 instance
        out_ready_s[1] = 1'b1;
        chk("c3_reset_rk_idx", 128'(rk_idx_s[1]), 128'd14);
        send(1, C3_CT, lat);
        chk("c3_latency", 128'(lat), 128'd15);
        chk("c3_out_data", out_data_s[1], PT);
        step();
        chk("c3_taken", 128'(out_valid_s[1]), 128'd0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
